// File: rtl/memory_responder.sv
// Word-addressed 32-bit memory with byte-masked writes and registered reads.
// Optional read wait states are enabled by defining MEM_WAITSTATE_EN.
module memory_responder #(
    parameter int WORDS       = 1536,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic        mem_rbusy,
    output logic        mem_err
);

    localparam int          AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] WORDS_L = 32'(WORDS);

    logic [31:0] mem [WORDS];

    logic        in_range;
    logic        wr_req;
    logic [AW-1:0] idx;

    assign in_range = {2'b00, mem_addr[31:2]} < WORDS_L;
    assign wr_req   = |mem_wmask;
    assign idx      = mem_addr[AW+1:2];

    // Contents are deliberately not reset so they survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && wr_req && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) begin
                    mem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef MEM_WAITSTATE_EN
    // state | meaning
    // IDLE  | ready to accept a read strobe
    // WAIT  | read accepted, counting wait states on the latched address
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [29:0] addr_q;
    logic        rd_accept;
    logic        rd_done;
    logic        addr_q_in_range;

    assign addr_q_in_range = {2'b00, addr_q} < WORDS_L;
    assign mem_rbusy       = (state_q == WAIT);

    always_comb begin
        state_d   = state_q;
        rd_accept = 1'b0;
        rd_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_rstrb) begin
                    state_d   = WAIT;
                    rd_accept = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    rd_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 30'd0;
            mem_rdata <= 32'd0;
            mem_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rd_accept) begin
                cnt_q  <= WAIT_LOAD;
                addr_q <= mem_addr[31:2];
            end else if (state_q == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (rd_done) begin
                mem_rdata <= addr_q_in_range ? mem[addr_q[AW-1:0]] : 32'd0;
            end
            mem_err <= (wr_req && !in_range) || (rd_done && !addr_q_in_range);
        end
    end

    wire unused_bits = &{1'b0, mem_addr[1:0]};
`else
    assign mem_rbusy = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= 32'd0;
            mem_err   <= 1'b0;
        end else begin
            if (mem_rstrb) begin
                mem_rdata <= in_range ? mem[idx] : 32'd0;
            end
            mem_err <= (mem_rstrb || wr_req) && !in_range;
        end
    end

    wire unused_bits = &{1'b0, mem_addr[1:0], 4'(WAIT_CYCLES)};
`endif

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter WORDS, default 1536, memory depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, read wait states; used only when MEM_WAITSTATE_EN is defined, range 1..15.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_addr  input  32  byte address from initiator.
REQ-006 SHALL have port mem_rstrb  input  1  read request, sampled on clk rising edge.
REQ-007 SHALL have port mem_rdata  output  32  registered read data.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_wmask  input  4  byte write enables; bit k writes bits 8k+7:8k.
REQ-010 SHALL have port mem_rbusy  output  1  read in progress, data not yet valid.
REQ-011 SHALL have port mem_err  output  1  one-cycle pulse on out-of-range access.

Function
REQ-012 SHALL decode word index = mem_addr[31:2]; mem_addr[1:0] ignored.
REQ-013 SHALL treat an access as in-range when word index < WORDS.
REQ-014 SHALL, without MEM_WAITSTATE_EN, on an edge with mem_rstrb=1 load mem_rdata with the addressed word; data valid in the cycle immediately after that edge (latency 1).
REQ-015 SHALL hold mem_rdata unchanged between accepted reads.
REQ-016 SHALL, on an edge with mem_wmask!=0 and in-range address, write only the enabled bytes of mem_wdata; write latency 1, no busy signalling.
REQ-017 SHALL, when read and write hit the same word on the same edge, return the pre-write contents (read-before-write) and commit the write.
REQ-018 SHALL, on an out-of-range read, load mem_rdata with 32'h0000_0000.
REQ-019 SHALL, on an out-of-range write, drop the write with no memory change.
REQ-020 SHALL assert mem_err for exactly the cycle after any edge carrying an out-of-range read or write; back-to-back errors keep it high.
REQ-021 SHALL accept a read on every edge with mem_rstrb=1 when mem_rbusy=0 (back-to-back reads, one per cycle).
REQ-022 SHALL hold mem_rbusy at 0 when MEM_WAITSTATE_EN is undefined.
REQ-023 SHALL accept writes regardless of mem_rbusy.

Reset
REQ-024 SHALL, while rst_n=0, force mem_rdata=0, mem_rbusy=0, mem_err=0 and the wait counter to 0, independent of clk.
REQ-025 SHALL NOT clear memory contents on reset; contents persist across reset.
REQ-026 SHALL abort a pending wait-state read on reset; no data delivered for it after release.
REQ-027 SHALL ignore mem_rstrb and mem_wmask on edges while rst_n=0.

Configuration
REQ-028 SHALL, with MEM_WAITSTATE_EN defined, implement FSM IDLE->WAIT->IDLE: accepted read at edge N latches address, sets mem_rbusy=1 from the cycle after edge N, counts WAIT_CYCLES edges, loads mem_rdata and clears mem_rbusy on edge N+WAIT_CYCLES.
REQ-029 SHALL, with MEM_WAITSTATE_EN defined, ignore mem_rstrb while mem_rbusy=1 (no queueing); memory read uses the latched address, and mem_err for out-of-range reads pulses in the cycle mem_rbusy falls.
REQ-030 SHALL, with MEM_WAITSTATE_EN undefined, contain no FSM and no wait counter; behaviour per REQ-014/REQ-022.

Verification
REQ-031 SHALL cover: write 32'hDEADBEEF to 0x10 mask 4'hF, then rstrb at 0x10 -> mem_rdata=32'hDEADBEEF one cycle later, mem_rbusy=0.
REQ-032 SHALL cover: word 0x20 = 32'h11223344, write 32'hAABBCCDD mask 4'b0101, read 0x22 -> 32'h11BB33DD.
REQ-033 SHALL cover: same-edge rstrb and write 32'h5 mask 4'hF to 0x8 holding 32'h7 -> rdata=32'h7; next read -> 32'h5.
REQ-034 SHALL cover: read address 4*WORDS -> rdata=0, mem_err high exactly one cycle; write there -> word 0 unchanged, mem_err pulse.
REQ-035 SHALL cover: MEM_WAITSTATE_EN, WAIT_CYCLES=2, rstrb at 0x0 edge N, extra rstrb at 0x4 edge N+1 -> mem_rbusy high for 2 cycles, rdata = word 0, second request ignored.
REQ-036 SHALL cover: rst_n low mid-wait, then released -> mem_rbusy=0, mem_rdata=0 immediately, previously written word 0x10 still reads 32'hDEADBEEF.
